// File: rtl/reflector_arbiter.sv
// Round-robin front end that shares one vector reflector pipeline among NUM_REQ
// ray units and routes each result back to the requester that issued it.
module reflector_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int PIPE_LATENCY = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*96-1:0] req_v,
  input  logic [NUM_REQ*96-1:0] req_n,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    resp_valid,
  output logic [95:0]           resp_r,
  output logic [95:0]           pipe_v,
  output logic [95:0]           pipe_n,
  output logic                  pipe_new_data,
  input  logic [95:0]           pipe_r,
  input  logic                  pipe_output_valid,
  output logic                  busy,
  output logic                  seq_error
);

  localparam int          IDW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int          CW     = $clog2(PIPE_LATENCY + 1);
  localparam int unsigned NREQ_U = NUM_REQ;
  localparam int unsigned LAT_U  = PIPE_LATENCY;

  typedef enum logic {
    DRAIN,
    RUN
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      drain_cnt;
  logic               drain_done;
  logic [IDW-1:0]     rr;
  logic [IDW-1:0]     grant_id;
  logic [NUM_REQ-1:0] grant_oh;
  logic               accept;
  logic [95:0]        sel_v, sel_n;
  logic [IDW-1:0]     issue_id;

  logic [PIPE_LATENCY-1:0] tag_vld;
  logic [IDW-1:0]          tag_id [PIPE_LATENCY];
  logic                    tail_vld;
  logic [IDW-1:0]          tail_id;
  logic [NUM_REQ-1:0]      tail_oh;
  logic                    pov_run;

  assign drain_done = (drain_cnt == CW'(PIPE_LATENCY - 1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= DRAIN;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst || state_q != DRAIN) drain_cnt <= '0;
    else                         drain_cnt <= drain_cnt + CW'(1);
  end

  // Next state plus the combinational grant: first valid requester at or after rr, wrapping.
  always_comb begin
    int unsigned    idx;
    logic [IDW-1:0] sel;
    logic           found;
    state_d  = state_q;
    grant_oh = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = 0;
    sel      = '0;
    case (state_q)
      DRAIN: if (drain_done) state_d = RUN;
      RUN: begin
        for (int unsigned k = 0; k < NREQ_U; k++) begin
          idx = 32'(rr) + k;
          if (idx >= NREQ_U) idx = idx - NREQ_U;
          sel = IDW'(idx);
          if (!found && req_valid[sel]) begin
            found         = 1'b1;
            grant_id      = sel;
            grant_oh[sel] = 1'b1;
          end
        end
      end
      default: state_d = DRAIN;
    endcase
  end

  assign req_ready = grant_oh;
  assign accept    = |(req_valid & grant_oh);

  always_comb begin
    sel_v = '0;
    sel_n = '0;
    for (int unsigned i = 0; i < NREQ_U; i++) begin
      if (grant_oh[i]) begin
        sel_v = req_v[i*96 +: 96];
        sel_n = req_n[i*96 +: 96];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_v        <= '0;
      pipe_n        <= '0;
      pipe_new_data <= 1'b0;
      issue_id      <= '0;
      rr            <= '0;
    end else begin
      pipe_new_data <= accept;
      if (accept) begin
        pipe_v   <= sel_v;
        pipe_n   <= sel_n;
        issue_id <= grant_id;
        rr       <= (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + IDW'(1);
      end
    end
  end

  // Stage 0 samples the issue strobe one edge after it is driven, so the tail
  // lines up with the reflector's output strobe PIPE_LATENCY cycles after issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld <= '0;
      for (int unsigned i = 0; i < LAT_U; i++) tag_id[i] <= '0;
    end else begin
      tag_vld[0] <= pipe_new_data;
      tag_id[0]  <= issue_id;
      for (int unsigned i = 1; i < LAT_U; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_id[i]  <= tag_id[i-1];
      end
    end
  end

  assign tail_vld = tag_vld[PIPE_LATENCY-1];
  assign tail_id  = tag_id[PIPE_LATENCY-1];
  assign pov_run  = pipe_output_valid && (state_q == RUN);

  always_comb begin
    tail_oh          = '0;
    tail_oh[tail_id] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid <= '0;
      resp_r     <= '0;
      seq_error  <= 1'b0;
    end else begin
      resp_valid <= '0;
      if (tail_vld && pov_run) begin
        resp_valid <= tail_oh;
        resp_r     <= pipe_r;
      end
      if (tail_vld != pov_run) seq_error <= 1'b1;
    end
  end

  assign busy = (|tag_vld) | pipe_new_data | (state_q == DRAIN);

endmodule

// File: tb/tb_reflector_arbiter.sv
// Directed bench for reflector_arbiter with a behavioural reflector/echo pipeline stub.
module tb_reflector_arbiter;
  localparam int N = 4;
  localparam int L = 12;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N*96-1:0] req_v, req_n;
  logic [N-1:0]   req_ready, resp_valid;
  logic [95:0]    resp_r, pipe_v, pipe_n, pipe_r;
  logic           pipe_new_data, pipe_output_valid, busy, seq_error;

  int checks = 0;
  int passes = 0;

  logic [95:0] v_tab [N];
  logic [95:0] n_tab [N];

  // Pipeline stub: not reset, so stale items really do come out during a drain.
  logic        stub_reflect = 1'b0;
  logic [3:0]  stub_sel = 4'd11;
  logic [15:0] sh_v = '0;
  logic [95:0] sh_d [16];

  always #5 clk = ~clk;

  reflector_arbiter #(.NUM_REQ(N), .PIPE_LATENCY(L)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_v(req_v), .req_n(req_n),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_r(resp_r),
    .pipe_v(pipe_v), .pipe_n(pipe_n), .pipe_new_data(pipe_new_data),
    .pipe_r(pipe_r), .pipe_output_valid(pipe_output_valid),
    .busy(busy), .seq_error(seq_error)
  );

  function automatic logic [95:0] reflect(input logic [95:0] v, input logic [95:0] n);
    longint vx, vy, vz, nx, ny, nz, dot, rx, ry, rz;
    vx = longint'($signed(v[31:0]));  vy = longint'($signed(v[63:32]));  vz = longint'($signed(v[95:64]));
    nx = longint'($signed(n[31:0]));  ny = longint'($signed(n[63:32]));  nz = longint'($signed(n[95:64]));
    dot = (vx*nx + vy*ny + vz*nz) >>> 24;
    rx = vx - ((2*dot*nx) >>> 24);
    ry = vy - ((2*dot*ny) >>> 24);
    rz = vz - ((2*dot*nz) >>> 24);
    return {rz[31:0], ry[31:0], rx[31:0]};
  endfunction

  always @(posedge clk) begin
    sh_v    <= {sh_v[14:0], pipe_new_data};
    sh_d[0] <= stub_reflect ? reflect(pipe_v, pipe_n) : pipe_v;
    for (int i = 1; i < 16; i++) sh_d[i] <= sh_d[i-1];
  end
  assign pipe_output_valid = sh_v[stub_sel];
  assign pipe_r            = sh_d[stub_sel];

  task automatic load_vectors();
    for (int i = 0; i < N; i++) begin
      req_v[i*96 +: 96] = v_tab[i];
      req_n[i*96 +: 96] = n_tab[i];
    end
  endtask

  // Leaves the bench one negedge before the first cycle in which req_ready may rise.
  task automatic do_reset();
    @(negedge clk); rst = 1'b1; req_valid = '0;
    @(negedge clk); rst = 1'b0;
    repeat (L - 1) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [N-1:0] e;
    rst = 1'b1; req_valid = '1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (req_ready !== '0) $display("FAIL reset_req_ready got=%b want=0", req_ready); else passes++;
    checks++; if (resp_valid !== '0) $display("FAIL reset_resp_valid got=%b want=0", resp_valid); else passes++;
    checks++; if (resp_r !== '0) $display("FAIL reset_resp_r got=%h want=0", resp_r); else passes++;
    checks++; if (pipe_v !== '0 || pipe_n !== '0) $display("FAIL reset_pipe_ops got=%h/%h want=0", pipe_v, pipe_n); else passes++;
    checks++; if (pipe_new_data !== 1'b0) $display("FAIL reset_pipe_new_data got=%b want=0", pipe_new_data); else passes++;
    checks++; if (seq_error !== 1'b0) $display("FAIL reset_seq_error got=%b want=0", seq_error); else passes++;
    checks++; if (busy !== 1'b1) $display("FAIL reset_busy got=%b want=1", busy); else passes++;
    rst = 1'b0;
    for (int k = 2; k <= L; k++) begin
      @(negedge clk); #1;
      checks++; if (req_ready !== '0) $display("FAIL drain_ready cyc=%0d got=%b want=0", k, req_ready); else passes++;
    end
    @(negedge clk); #1;
    e = 4'b0001;
    checks++; if (req_ready !== e) $display("FAIL drain_end_ready got=%b want=%b", req_ready, e); else passes++;
    req_valid = '0;
  endtask

  task automatic test_single();
    int          first_k = -1;
    int          pulses = 0;
    logic [N-1:0] got_oh = '0;
    logic [95:0] got_r = '0;
    logic [95:0] exp_r;
    logic [N-1:0] e;
    int          dx, dy, dz;
    exp_r = {32'hFF6C32C6, 32'h0093CD3A, 32'hFF6C32C6};
    stub_reflect = 1'b1;
    v_tab[2] = {32'hFF6C32C6, 32'hFF6C32C6, 32'hFF6C32C6};
    n_tab[2] = {32'h0, 32'h01000000, 32'h0};
    load_vectors();
    @(negedge clk); req_valid = 4'b0100; #1;
    e = 4'b0100;
    checks++; if (req_ready !== e) $display("FAIL single_grant got=%b want=%b", req_ready, e); else passes++;
    @(negedge clk); req_valid = '0; #1;
    checks++; if (pipe_new_data !== 1'b1) $display("FAIL single_issue_strobe got=%b want=1", pipe_new_data); else passes++;
    checks++; if (pipe_v !== v_tab[2] || pipe_n !== n_tab[2])
      $display("FAIL single_issue_ops got=%h/%h want=%h/%h", pipe_v, pipe_n, v_tab[2], n_tab[2]); else passes++;
    for (int k = 2; k <= 30; k++) begin
      @(negedge clk); #1;
      if (resp_valid !== '0) begin
        if (first_k < 0) begin first_k = k; got_oh = resp_valid; got_r = resp_r; end
        pulses++;
      end
    end
    checks++; if (first_k != L + 2 || pulses != 1)
      $display("FAIL single_latency got=cyc%0d x%0d want=cyc%0d x1", first_k, pulses, L + 2); else passes++;
    checks++; if (got_oh !== e) $display("FAIL single_resp_id got=%b want=%b", got_oh, e); else passes++;
    dx = $signed(got_r[31:0]) - $signed(exp_r[31:0]);
    dy = $signed(got_r[63:32]) - $signed(exp_r[63:32]);
    dz = $signed(got_r[95:64]) - $signed(exp_r[95:64]);
    if (dx < 0) dx = -dx;
    if (dy < 0) dy = -dy;
    if (dz < 0) dz = -dz;
    checks++; if (dx > 256 || dy > 256 || dz > 256)
      $display("FAIL single_resp_r got=%h want=%h (+-2^-16)", got_r, exp_r); else passes++;
    stub_reflect = 1'b0;
  endtask

  task automatic test_round_robin();
    int          nresp = 0;
    int          rk [16];
    logic [N-1:0] roh [16];
    logic [95:0] rd [16];
    logic [N-1:0] e;
    do_reset();
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      req_valid = (k < 8) ? '1 : '0;
      #1;
      if (k < 8) begin
        e = 4'b0001 << (k % 4);
        checks++; if (req_ready !== e) $display("FAIL rr_grant k=%0d got=%b want=%b", k, req_ready, e); else passes++;
      end
      if (resp_valid !== '0) begin
        if (nresp < 16) begin rk[nresp] = k; roh[nresp] = resp_valid; rd[nresp] = resp_r; end
        nresp++;
      end
    end
    checks++; if (nresp != 8) $display("FAIL rr_resp_count got=%0d want=8", nresp); else passes++;
    for (int j = 0; j < 8 && j < nresp; j++) begin
      e = 4'b0001 << (j % 4);
      checks++; if (rk[j] != j + L + 2 || roh[j] !== e || rd[j] !== v_tab[j % 4])
        $display("FAIL rr_resp j=%0d got=cyc%0d %b %h want=cyc%0d %b %h", j, rk[j], roh[j], rd[j], j + L + 2, e, v_tab[j % 4]);
      else passes++;
    end
  endtask

  task automatic test_fairness();
    logic [N-1:0] exp_g [8];
    int          nresp = 0;
    int          rk [16];
    logic [N-1:0] roh [16];
    exp_g = '{4'b0010, 4'b1000, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000, 4'b0010};
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (k < 8) req_valid = 4'b1010 | ((k == 3 || k == 4) ? 4'b0001 : 4'b0000);
      else       req_valid = '0;
      #1;
      if (k < 8) begin
        checks++; if (req_ready !== exp_g[k]) $display("FAIL fair_grant k=%0d got=%b want=%b", k, req_ready, exp_g[k]); else passes++;
      end
      if (resp_valid !== '0) begin
        if (nresp < 16) begin rk[nresp] = k; roh[nresp] = resp_valid; end
        nresp++;
      end
    end
    checks++; if (nresp != 8) $display("FAIL fair_resp_count got=%0d want=8", nresp); else passes++;
    for (int j = 0; j < 8 && j < nresp; j++) begin
      checks++; if (rk[j] != j + L + 2 || roh[j] !== exp_g[j])
        $display("FAIL fair_resp j=%0d got=cyc%0d %b want=cyc%0d %b", j, rk[j], roh[j], j + L + 2, exp_g[j]);
      else passes++;
    end
  endtask

  task automatic test_reset_midflight();
    int          nresp = 0;
    int          rk [16];
    logic [N-1:0] roh [16];
    logic [95:0] rd [16];
    logic [N-1:0] e;
    e = 4'b0001;
    for (int k = 0; k < 45; k++) begin
      @(negedge clk);
      if (k < 3)       req_valid = 4'b0001;
      else if (k == 3) begin req_valid = '0; rst = 1'b1; end
      else if (k < 18) begin req_valid = 4'b0001; rst = 1'b0; end
      else             req_valid = '0;
      #1;
      if (k < 3 || k == 16) begin
        checks++; if (req_ready !== e) $display("FAIL mid_grant k=%0d got=%b want=%b", k, req_ready, e); else passes++;
      end
      if (k >= 4 && k <= 15) begin
        checks++; if (req_ready !== '0) $display("FAIL mid_drain_ready k=%0d got=%b want=0", k, req_ready); else passes++;
      end
      if (resp_valid !== '0) begin
        if (nresp < 16) begin rk[nresp] = k; roh[nresp] = resp_valid; rd[nresp] = resp_r; end
        nresp++;
      end
    end
    checks++; if (nresp != 2) $display("FAIL mid_resp_count got=%0d want=2", nresp); else passes++;
    for (int j = 0; j < 2 && j < nresp; j++) begin
      checks++; if (rk[j] != 16 + j + L + 2 || roh[j] !== e || rd[j] !== v_tab[0])
        $display("FAIL mid_resp j=%0d got=cyc%0d %b %h want=cyc%0d %b %h", j, rk[j], roh[j], rd[j], 16 + j + L + 2, e, v_tab[0]);
      else passes++;
    end
    checks++; if (seq_error !== 1'b0) $display("FAIL mid_seq_error got=%b want=0", seq_error); else passes++;
  endtask

  task automatic test_mismatch();
    int          nresp = 0;
    logic [N-1:0] e;
    e = 4'b0010;
    stub_sel = 4'd12;
    for (int k = 0; k < 31; k++) begin
      @(negedge clk);
      req_valid = (k == 0) ? 4'b0010 : 4'b0000;
      #1;
      if (k == 0) begin
        checks++; if (req_ready !== e) $display("FAIL mism_grant got=%b want=%b", req_ready, e); else passes++;
      end
      if (k == 13) begin
        checks++; if (seq_error !== 1'b0) $display("FAIL mism_err_early got=%b want=0", seq_error); else passes++;
      end
      if (k == 14) begin
        checks++; if (seq_error !== 1'b1) $display("FAIL mism_err_set got=%b want=1", seq_error); else passes++;
      end
      if (resp_valid !== '0) nresp++;
    end
    checks++; if (nresp != 0) $display("FAIL mism_resp_count got=%0d want=0", nresp); else passes++;
    checks++; if (seq_error !== 1'b1) $display("FAIL mism_err_sticky got=%b want=1", seq_error); else passes++;
    stub_sel = 4'd11;
    do_reset();
    #1;
    checks++; if (seq_error !== 1'b0) $display("FAIL mism_err_cleared got=%b want=0", seq_error); else passes++;
  endtask

  task automatic test_idle();
    req_valid = '0;
    repeat (50) @(negedge clk);
    #1;
    checks++; if (busy !== 1'b0) $display("FAIL idle_busy got=%b want=0", busy); else passes++;
    checks++; if (pipe_new_data !== 1'b0) $display("FAIL idle_pipe_new_data got=%b want=0", pipe_new_data); else passes++;
    checks++; if (seq_error !== 1'b0) $display("FAIL idle_seq_error got=%b want=0", seq_error); else passes++;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      v_tab[i] = {32'h0300_0000 + 32'(i), 32'h0200_0000 + 32'(i), 32'h0100_0000 + 32'(i)};
      n_tab[i] = {32'h0000_0010 * 32'(i), 32'h0100_0000, 32'h0000_0020 + 32'(i)};
    end
    load_vectors();
    test_reset();
    test_single();
    test_round_robin();
    test_fairness();
    test_reset_midflight();
    test_mismatch();
    test_idle();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout bench did not complete got=running want=done");
    $fatal(1);
  end

endmodule

// File: doc/reflector_arbiter.md
# reflector_arbiter

Round-robin scheduler that shares one `vector_reflector_pipeline` among `NUM_REQ` ray units. It accepts reflect requests (incident vector `v`, normal `n`, each 3 × Q8.24), issues at most one per cycle into the pipeline, and tracks the requester ID of every in-flight item in a tag line matched to the pipeline latency. It routes each result back to the requester that issued it. The block sits between the per-ray bounce logic and the single reflector instance.

## Interface

- `NUM_REQ`, default 4: number of requesters, range 2–8.
- `PIPE_LATENCY`, default 12: cycles from `pipe_new_data` to `pipe_output_valid`. Must equal the reflector's latency.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in NUM_REQ: per-requester request pending.
- `req_v` in NUM_REQ×96: incident vectors. Requester i occupies [96i+95:96i]; components are x=[31:0], y=[63:32], z=[95:64], signed Q8.24.
- `req_n` in NUM_REQ×96: normals, same packing.
- `req_ready` out NUM_REQ: one-hot grant. Accept occurs when `req_valid[i] & req_ready[i]`.
- `resp_valid` out NUM_REQ: one-hot, one-cycle pulse marking the owner of `resp_r`.
- `resp_r` out 96: reflected vector, broadcast to all requesters.
- `pipe_v`, `pipe_n` out 96: registered operands to the reflector.
- `pipe_new_data` out 1: registered issue strobe.
- `pipe_r` in 96: reflector result.
- `pipe_output_valid` in 1: reflector result strobe.
- `busy` out 1: high while any tag is in flight or a drain is active.
- `seq_error` out 1: sticky flag for tag/result mismatch.

## Operation

- **States:**
  - DRAIN: entered on `rst`. Counts `PIPE_LATENCY` cycles with `req_ready`=0 and `pipe_output_valid` ignored. This flushes stale pipeline contents. Then moves to RUN.
  - RUN: normal arbitration.
- **Arbitration in RUN:**
  - Round-robin pointer `rr` (reset 0). Grant goes to the first `i` with `req_valid[i]`, searching from `rr` upward and wrapping.
  - `req_ready` is combinational from `req_valid` and `rr`. At most one bit is set; it is all-zero if no request or not in RUN.
  - On accept by requester g: `rr` ← (g+1) mod NUM_REQ. `rr` holds when there is no accept.
  - A requester holding `req_valid` is granted within NUM_REQ cycles.
- **Issue:** on accept, the next edge registers `pipe_v`/`pipe_n` from the selected slice and sets `pipe_new_data`=1 for exactly one cycle. Operands are passed bit-exact with no arithmetic.
- **Tag line:**
  - Shift register of `PIPE_LATENCY` entries, each {valid, id[$clog2(NUM_REQ)-1:0]}.
  - Stage 0 loads {`pipe_new_data`, issued id} each cycle.
  - The tail aligns with `pipe_output_valid`.
- **Return:**
  - If tail valid and `pipe_output_valid` are both high: next edge sets `resp_r` ← `pipe_r` and `resp_valid` ← one-hot(tail id).
  - If tail valid and `pipe_output_valid` differ: no response, and `seq_error` is set and stays set until `rst`.
- **Requester obligation:** there is no response backpressure. Requesters must accept `resp_valid` unconditionally.
- **`busy`:** OR of all tag valid bits, `pipe_new_data`, and (state==DRAIN).
- **`rst` mid-operation:** all in-flight tags are discarded and none of their results are returned. Then DRAIN runs.

## Timing

- **Reset values** (first edge with `rst`=1):
  - `req_ready`=0, `resp_valid`=0, `resp_r`=0, `pipe_v`=0, `pipe_n`=0, `pipe_new_data`=0, `seq_error`=0.
  - `busy`=1, state=DRAIN, drain counter=0, all tags invalid, `rr`=0.
- **Drain:** `req_ready` can first be high `PIPE_LATENCY` cycles after the first edge with `rst`=0.
- **Latency:** accept at edge t → `pipe_new_data` high in cycle t+1 → `pipe_output_valid` expected in cycle t+1+`PIPE_LATENCY` → `resp_valid` high in cycle t+2+`PIPE_LATENCY`.
- **Throughput:** one accept per cycle. Back-to-back accepts produce back-to-back responses in issue order.
- **Simultaneous events:** issue and return in the same cycle are independent. A `pipe_output_valid` arriving in the same cycle as `rst` is dropped.

## Test plan

- **Single request (real reflector, `PIPE_LATENCY` matched):**
  - Stimulus: requester 2 sends v=(0xFF6C32C6, 0xFF6C32C6, 0xFF6C32C6) and n=(0, 0x01000000, 0).
  - Required: `resp_valid`=4'b0100 exactly `PIPE_LATENCY`+2 cycles after accept; `resp_r` ≈ (−0.577, +0.577, −0.577) within 2⁻¹⁶.
- **All requesters asserted continuously (echo stub, latency 12):**
  - Required grant order is 0,1,2,3,0,…
  - Required: each response id matches its issue order; 8 accepts produce 8 consecutive `resp_valid` pulses.
- **Fairness:** requesters 1 and 3 always valid, requester 0 pulses once. Requester 0 is granted within 4 cycles and the 1/3 alternation resumes.
- **Reset mid-flight:** issue 5 requests, assert `rst` for 1 cycle after the 3rd issue.
  - Required: no `resp_valid` for any pre-reset item.
  - Required: `req_ready`=0 for 12 cycles after reset, then a new request returns normally.
- **Mismatch:** stub delays `pipe_output_valid` by 1 extra cycle. Required: no `resp_valid`, and `seq_error`=1 from the cycle after the tail mismatch, staying set until `rst`.
- **Idle:** no requests for 50 cycles after drain. Required: `busy`=0, `pipe_new_data`=0, `seq_error`=0.
